// File: rtl/vote_collector_if.sv
// vote_collector_if: bundles the ballot handshake and the result signals of vote_collector.
//   start        open a new ballot session (honoured only when the collector is idle)
//   cast_valid   a voter presents a vote this cycle
//   cast_id      voter index 0..3
//   cast_vote    1 = yes, 0 = no
//   cast_ready   a vote can be accepted this cycle
//   ballot       collected vote vector, bit[id] = vote of voter id
//   ballot_valid one-cycle pulse marking the ballot final
//   voted        mask of voters that have cast in the current/last session
//   busy         session in progress (collecting or closing)
//   timeout      last session closed by the timer rather than by four votes
//   dup_err      one-cycle pulse: a repeat vote was rejected
// The master modport belongs to whoever drives votes; the slave modport is the collector.
interface vote_collector_if;
    logic       start;
    logic       cast_valid;
    logic [1:0] cast_id;
    logic       cast_vote;
    logic       cast_ready;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic [3:0] voted;
    logic       busy;
    logic       timeout;
    logic       dup_err;

    modport master (
        output start,
        output cast_valid,
        output cast_id,
        output cast_vote,
        input  cast_ready,
        input  ballot,
        input  ballot_valid,
        input  voted,
        input  busy,
        input  timeout,
        input  dup_err
    );

    modport slave (
        input  start,
        input  cast_valid,
        input  cast_id,
        input  cast_vote,
        output cast_ready,
        output ballot,
        output ballot_valid,
        output voted,
        output busy,
        output timeout,
        output dup_err
    );
endinterface

// File: rtl/vote_collector.sv
// vote_collector: collects one yes/no vote from each of four voters per ballot session.
// A session opens on start while idle, accepts at most one vote per voter, and closes either
// when all four have voted or after TIMEOUT collecting cycles. The closing cycle pulses
// ballot_valid; ballot/voted/timeout then hold until the next start.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  vote_collector_if.slave (start/cast handshake in, ballot results out)
// Parameter:
//   TIMEOUT  collecting cycles before a session is forcibly closed (4..65535)
module vote_collector #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    vote_collector_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StCollect = 2'b01,
        StDone    = 2'b10
    } state_e;

    // Timer value seen during the last permitted collecting cycle.
    localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  ballot_q, ballot_d;
    logic [3:0]  voted_q, voted_d;
    logic        timeout_q, timeout_d;
    logic        ballot_valid_q, ballot_valid_d;
    logic        busy_q, busy_d;
    logic        dup_err_q, dup_err_d;

    // Datapath helpers for the collecting state.
    logic       cast_ready;
    logic       cast_fire;
    logic [3:0] id_mask;
    logic       is_dup;
    logic       is_new;
    logic [3:0] voted_upd;
    logic [3:0] ballot_upd;
    logic       all_in;
    logic       expired;

    // Ready is a pure decode of the state register so it never depends on inputs.
    assign cast_ready = (state_q == StCollect);

    always_comb begin
        cast_fire  = bus.cast_valid && cast_ready;
        id_mask    = 4'b0001 << bus.cast_id;
        is_dup     = cast_fire && ((voted_q & id_mask) != 4'b0000);
        is_new     = cast_fire && ((voted_q & id_mask) == 4'b0000);
        voted_upd  = voted_q;
        ballot_upd = ballot_q;
        if (is_new) begin
            voted_upd  = voted_q | id_mask;
            ballot_upd = (ballot_q & ~id_mask) | (bus.cast_vote ? id_mask : 4'b0000);
        end
        // Completion is judged on the mask including this edge's vote, so a final vote
        // arriving together with timer expiry still counts as a full ballot.
        all_in  = (voted_upd == 4'b1111);
        expired = (timer_q == TimerLast);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle:    state_d = bus.start ? StCollect : StIdle;
            StCollect: state_d = (all_in || expired) ? StDone : StCollect;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the session timer.
    always_comb begin
        timer_d        = timer_q;
        ballot_d       = ballot_q;
        voted_d        = voted_q;
        timeout_d      = timeout_q;
        dup_err_d      = 1'b0;
        ballot_valid_d = (state_d == StDone);
        busy_d         = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    timer_d   = 16'd0;
                    ballot_d  = 4'b0000;
                    voted_d   = 4'b0000;
                    timeout_d = 1'b0;
                end
            end
            StCollect: begin
                ballot_d  = ballot_upd;
                voted_d   = voted_upd;
                dup_err_d = is_dup;
                if (timer_q != 16'hffff) begin
                    timer_d = timer_q + 16'd1;
                end
                if (expired && !all_in) begin
                    timeout_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q        <= 16'd0;
            ballot_q       <= 4'b0000;
            voted_q        <= 4'b0000;
            timeout_q      <= 1'b0;
            ballot_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            dup_err_q      <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            ballot_q       <= ballot_d;
            voted_q        <= voted_d;
            timeout_q      <= timeout_d;
            ballot_valid_q <= ballot_valid_d;
            busy_q         <= busy_d;
            dup_err_q      <= dup_err_d;
        end
    end

    assign bus.cast_ready   = cast_ready;
    assign bus.ballot       = ballot_q;
    assign bus.voted        = voted_q;
    assign bus.timeout      = timeout_q;
    assign bus.ballot_valid = ballot_valid_q;
    assign bus.busy         = busy_q;
    assign bus.dup_err      = dup_err_q;

endmodule
